// File: rtl/quad_step_decoder_if.sv
// Quadrature decoder bus: phase inputs and clear in, position and event pulses out.
// Latency: none, wiring only.
// Backpressure: none, the decoder consumes phase samples every clock.
interface quad_step_decoder_if #(
   parameter int WIDTH = 3
);
   logic             a_in;
   logic             b_in;
   logic             clr;
   logic [WIDTH-1:0] count;
   logic             updown;
   logic             step;
   logic             err;
   logic             err_flag;

   modport master (
      output a_in, b_in, clr,
      input  count, updown, step, err, err_flag
   );

   modport slave (
      input  a_in, b_in, clr,
      output count, updown, step, err, err_flag
   );
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: synchronises phases, emits step/err pulses, tracks position.
// Latency: a phase edge stable before clk edge k reaches the outputs at edge k+SYNC_STAGES.
// Backpressure: none; one decode every clock, no stall path.
module quad_step_decoder #(
   parameter int WIDTH       = 3,
   parameter int SYNC_STAGES = 2
) (
   input logic                clk,
   input logic                rst,
   quad_step_decoder_if.slave bus
);
   // FILL waits until the synchroniser holds post-reset samples, so an encoder
   // resting at a non-00 phase is not mistaken for a jump from the reset value.
   typedef enum logic {ST_FILL, ST_RUN} state_t;

   state_t                 state_q, state_n;
   logic [2:0]             fill_q, fill_n;
   logic [SYNC_STAGES-1:0] a_sync, b_sync;
   logic [1:0]             phase;
   logic [1:0]             prev_q, prev_n;
   logic [WIDTH-1:0]       count_q, count_n;
   logic                   updown_q, updown_n;
   logic                   step_q, step_n;
   logic                   err_q, err_n;
   logic                   flag_q, flag_n;

   assign phase = {b_sync[SYNC_STAGES-1], a_sync[SYNC_STAGES-1]};

   // Synchroniser shift chains for the asynchronous phase inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sync <= '0;
         b_sync <= '0;
      end else begin
         a_sync <= {a_sync[SYNC_STAGES-2:0], bus.a_in};
         b_sync <= {b_sync[SYNC_STAGES-2:0], bus.b_in};
      end
   end

   // Priming state register and synchroniser fill counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FILL;
         fill_q  <= '0;
      end else begin
         state_q <= state_n;
         fill_q  <= fill_n;
      end
   end

   // Position, direction, event pulses and previous phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q   <= 2'b00;
         count_q  <= '0;
         updown_q <= 1'b0;
         step_q   <= 1'b0;
         err_q    <= 1'b0;
         flag_q   <= 1'b0;
      end else begin
         prev_q   <= prev_n;
         count_q  <= count_n;
         updown_q <= updown_n;
         step_q   <= step_n;
         err_q    <= err_n;
         flag_q   <= flag_n;
      end
   end

   // Next-state: priming sequence, Gray transition decode, then clear.
   always_comb begin
      state_n  = state_q;
      fill_n   = fill_q;
      prev_n   = phase;
      count_n  = count_q;
      updown_n = updown_q;
      step_n   = 1'b0;
      err_n    = 1'b0;
      flag_n   = flag_q;

      case (state_q)
         ST_FILL: begin
            if (fill_q == 3'(SYNC_STAGES)) state_n = ST_RUN;
            else                           fill_n  = fill_q + 3'd1;
         end
         ST_RUN: begin
            case ({prev_q, phase})
               4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
                  count_n  = count_q + WIDTH'(1);
                  updown_n = 1'b1;
                  step_n   = 1'b1;
               end
               4'b0100, 4'b1101, 4'b1011, 4'b0010: begin
                  count_n  = count_q - WIDTH'(1);
                  updown_n = 1'b0;
                  step_n   = 1'b1;
               end
               4'b0011, 4'b1100, 4'b0110, 4'b1001: begin
                  err_n  = 1'b1;
                  flag_n = 1'b1;
               end
               default: ;
            endcase
         end
         default: state_n = ST_FILL;
      endcase

      // Clear zeroes the position; an error decoded in the same cycle keeps the flag set.
      if (bus.clr) begin
         count_n = '0;
         flag_n  = err_n;
      end
   end

   assign bus.count    = count_q;
   assign bus.updown   = updown_q;
   assign bus.step     = step_q;
   assign bus.err      = err_q;
   assign bus.err_flag = flag_q;
endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed segment table, hand sequences, random walk vs model.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: none; inputs driven every cycle.
module tb_quad_step_decoder;
   localparam int W    = 3;
   localparam int SYNC = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   quad_step_decoder_if #(.WIDTH(W)) bus ();

   quad_step_decoder #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int steps_seen, errs_seen;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: delay line of tagged samples; events from Gray index difference.
   typedef struct packed {logic vld; logic [1:0] ph;} smp_t;
   smp_t     dq[$];
   int       m_pos;
   bit       m_dir, m_step, m_err, m_flag, m_have_last;
   logic [1:0] m_last;

   function automatic int gidx(input logic [1:0] ph);
      int gmap[4] = '{0, 1, 3, 2};
      return gmap[ph];
   endfunction

   task automatic model_edge(input logic r, input logic a, input logic b, input logic c);
      smp_t s;
      int   d;
      if (r) begin
         m_pos = 0; m_dir = 0; m_step = 0; m_err = 0; m_flag = 0; m_have_last = 0;
         dq.delete();
         for (int i = 0; i < SYNC; i++) dq.push_back('{1'b0, 2'b00});
      end else begin
         s = dq.pop_front();
         dq.push_back('{1'b1, {b, a}});
         m_step = 0;
         m_err  = 0;
         if (s.vld) begin
            if (m_have_last) begin
               d = (gidx(s.ph) - gidx(m_last) + 4) % 4;
               if (d == 1) begin
                  m_pos = (m_pos + 1) % (1 << W); m_dir = 1; m_step = 1;
               end else if (d == 3) begin
                  m_pos = (m_pos + (1 << W) - 1) % (1 << W); m_dir = 0; m_step = 1;
               end else if (d == 2) begin
                  m_err = 1; m_flag = 1;
               end
            end
            m_last      = s.ph;
            m_have_last = 1;
         end
         if (c) begin
            m_pos  = 0;
            m_flag = m_err;
         end
      end
   endtask

   // One clock: drive inputs, advance model at the rising edge, compare at the falling edge.
   task automatic cycle(input logic r, input logic a, input logic b, input logic c);
      rst      = r;
      bus.a_in = a;
      bus.b_in = b;
      bus.clr  = c;
      @(posedge clk);
      model_edge(r, a, b, c);
      @(negedge clk);
      cyc++;
      steps_seen += int'(bus.step);
      errs_seen  += int'(bus.err);
      chk($sformatf("cyc%0d_count", cyc),  int'(bus.count),    m_pos);
      chk($sformatf("cyc%0d_updown", cyc), int'(bus.updown),   int'(m_dir));
      chk($sformatf("cyc%0d_step", cyc),   int'(bus.step),     int'(m_step));
      chk($sformatf("cyc%0d_err", cyc),    int'(bus.err),      int'(m_err));
      chk($sformatf("cyc%0d_flag", cyc),   int'(bus.err_flag), int'(m_flag));
      chk($sformatf("cyc%0d_excl", cyc),   int'(bus.step & bus.err), 0);
   endtask

   typedef struct {
      logic       rst;
      logic [1:0] ph;   // {b, a}
      logic       clr;
      int         cyc;
      int         e_count;
      logic       e_ud;
      logic       e_flag;
      int         e_steps;
      int         e_errs;
   } seg_t;
   seg_t tbl[$];

   function automatic void add(input logic r, input logic [1:0] ph, input logic c, input int n,
                               input int ec, input logic eu, input logic ef,
                               input int es, input int ee);
      tbl.push_back('{r, ph, c, n, ec, eu, ef, es, ee});
   endfunction

   initial begin
      logic [1:0] gray[4] = '{2'b00, 2'b01, 2'b11, 2'b10};
      int pi, mv, hold;
      logic r, c;
      logic [1:0] ph;

      bus.a_in = 1'b0; bus.b_in = 1'b0; bus.clr = 1'b0;
      steps_seen = 0; errs_seen = 0;

      // rst ph clr n  count ud flag steps errs
      add(1, 2'b11, 0, 2,  0, 0, 0, 0, 0);
      add(0, 2'b11, 0, 12, 0, 0, 0, 0, 0);
      add(1, 2'b00, 0, 2,  0, 0, 0, 0, 0);
      add(0, 2'b00, 0, 4,  0, 0, 0, 0, 0);
      add(0, 2'b01, 0, 4,  1, 1, 0, 1, 0);
      add(0, 2'b11, 0, 4,  2, 1, 0, 1, 0);
      add(0, 2'b10, 0, 4,  3, 1, 0, 1, 0);
      add(0, 2'b00, 0, 4,  4, 1, 0, 1, 0);
      add(0, 2'b01, 0, 4,  5, 1, 0, 1, 0);
      add(0, 2'b11, 0, 4,  6, 1, 0, 1, 0);
      add(0, 2'b10, 0, 4,  7, 1, 0, 1, 0);
      add(0, 2'b00, 0, 4,  0, 1, 0, 1, 0);
      add(0, 2'b10, 0, 4,  7, 0, 0, 1, 0);
      add(0, 2'b11, 0, 4,  6, 0, 0, 1, 0);
      add(0, 2'b01, 0, 4,  5, 0, 0, 1, 0);
      add(0, 2'b00, 0, 4,  4, 0, 0, 1, 0);
      add(0, 2'b11, 0, 4,  4, 0, 1, 0, 1);
      add(0, 2'b10, 0, 4,  5, 1, 1, 1, 0);
      add(0, 2'b10, 1, 1,  0, 1, 0, 0, 0);
      add(0, 2'b10, 0, 3,  0, 1, 0, 0, 0);
      add(0, 2'b00, 0, 4,  1, 1, 0, 1, 0);
      add(0, 2'b01, 0, 4,  2, 1, 0, 1, 0);
      add(0, 2'b11, 0, 4,  3, 1, 0, 1, 0);
      add(1, 2'b11, 0, 1,  0, 0, 0, 0, 0);
      add(0, 2'b11, 0, 6,  0, 0, 0, 0, 0);
      add(0, 2'b10, 0, 4,  1, 1, 0, 1, 0);

      foreach (tbl[i]) begin
         steps_seen = 0;
         errs_seen  = 0;
         for (int j = 0; j < tbl[i].cyc; j++)
            cycle(tbl[i].rst, tbl[i].ph[0], tbl[i].ph[1], tbl[i].clr);
         chk($sformatf("seg%0d_count", i), int'(bus.count),    tbl[i].e_count);
         chk($sformatf("seg%0d_updown", i), int'(bus.updown),  int'(tbl[i].e_ud));
         chk($sformatf("seg%0d_flag", i),  int'(bus.err_flag), int'(tbl[i].e_flag));
         chk($sformatf("seg%0d_steps", i), steps_seen,         tbl[i].e_steps);
         chk($sformatf("seg%0d_errs", i),  errs_seen,          tbl[i].e_errs);
      end

      // Edge-to-output latency, clear colliding with a step, clear colliding with an error.
      cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);
      for (int j = 0; j < 5; j++) cycle(0, 0, 0, 0);
      chk("lat_start_count", int'(bus.count), 0);
      cycle(0, 1, 0, 0);
      chk("lat_k_step", int'(bus.step), 0);
      cycle(0, 1, 0, 0);
      chk("lat_k1_step", int'(bus.step), 0);
      chk("lat_k1_count", int'(bus.count), 0);
      cycle(0, 1, 0, 0);
      chk("lat_k2_step", int'(bus.step), 1);
      chk("lat_k2_count", int'(bus.count), 1);
      chk("lat_k2_updown", int'(bus.updown), 1);
      cycle(0, 1, 0, 0);
      chk("lat_k3_step", int'(bus.step), 0);

      cycle(0, 1, 1, 0); cycle(0, 1, 1, 0); cycle(0, 1, 1, 1);
      chk("clrstep_count", int'(bus.count), 0);
      chk("clrstep_step", int'(bus.step), 1);
      chk("clrstep_updown", int'(bus.updown), 1);
      cycle(0, 1, 1, 0);

      cycle(0, 0, 0, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 1);
      chk("clrerr_err", int'(bus.err), 1);
      chk("clrerr_flag", int'(bus.err_flag), 1);
      chk("clrerr_count", int'(bus.count), 0);
      chk("clrerr_step", int'(bus.step), 0);
      cycle(0, 0, 0, 0);
      chk("clrerr_after_err", int'(bus.err), 0);
      chk("clrerr_after_flag", int'(bus.err_flag), 1);

      // Random walk: legal moves, jumps, fast toggles, sporadic clear and reset.
      pi = 0;
      for (int n = 0; n < 600; n++) begin
         mv = $urandom_range(0, 9);
         if (mv < 4)       pi = (pi + 1) % 4;
         else if (mv < 8)  pi = (pi + 3) % 4;
         else if (mv == 8) pi = (pi + 2) % 4;
         ph   = gray[pi];
         hold = $urandom_range(1, 4);
         r    = ($urandom_range(0, 79) == 0);
         for (int h = 0; h < hold; h++) begin
            c = ($urandom_range(0, 15) == 0);
            cycle(r && (h == 0), ph[0], ph[1], c);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
